// File: rtl/muldiv_iter_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// Handshake: a transfer happens on a rising edge where valid && ready are both high;
// valid is never gated by ready, and payload must stay stable while valid && !ready.
interface muldiv_iter_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  opcode;
  logic [31:0] operator_1_c;
  logic [31:0] operator_2_c;
  logic        neg_1;
  logic        neg_2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;
  logic [1:0]  dbg_state;

  modport master (
    output in_valid, opcode, operator_1_c, operator_2_c, neg_1, neg_2, flush, out_ready,
    input  in_ready, out_valid, result, busy, dbg_state
  );

  modport slave (
    input  in_valid, opcode, operator_1_c, operator_2_c, neg_1, neg_2, flush, out_ready,
    output in_ready, out_valid, result, busy, dbg_state
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply (shift-add) / divide (restoring) unit on signed magnitudes.
// Optional macro MULDIV_EARLY_OUT_EN: a zero second operand skips the iteration phase.
module muldiv_iter (
  input logic          clk,
  input logic          rst_n,
  muldiv_iter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [4:0] OP_MUL    = 5'b00010;
  localparam logic [4:0] OP_MULH   = 5'b00011;
  localparam logic [4:0] OP_MULHSU = 5'b00100;
  localparam logic [4:0] OP_MULHU  = 5'b00101;
  localparam logic [4:0] OP_DIV    = 5'b00110;
  localparam logic [4:0] OP_DIVU   = 5'b00111;
  localparam logic [4:0] OP_REM    = 5'b01000;
  localparam logic [4:0] OP_REMU   = 5'b01001;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        neg1_q, neg1_d;
  logic        neg2_q, neg2_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] result_q, result_d;

  logic        accept;
  logic        in_is_mul, in_is_div;
  logic        q_is_mul;
  logic        early_out;
  logic [32:0] mul_sum;
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_sub;
  logic        mul_neg;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] fix_result;

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    in_is_mul = 1'b0;
    in_is_div = 1'b0;
    case (bus.opcode)
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: in_is_mul = 1'b1;
      OP_DIV, OP_DIVU, OP_REM, OP_REMU:     in_is_div = 1'b1;
      default: ;
    endcase
  end

  assign q_is_mul = (op_q == OP_MUL) || (op_q == OP_MULH) ||
                    (op_q == OP_MULHSU) || (op_q == OP_MULHU);

`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = (bus.operator_2_c == 32'd0);
`else
  assign early_out = 1'b0;
`endif

  // One shift-add step: the low half holds the unconsumed multiplier bits.
  assign mul_sum = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, op1_q} : 33'd0);

  // One restoring step: the quotient register still holds the unconsumed dividend bits.
  assign rem_shift = {rem_q, quo_q[31]};
  assign rem_ge    = (rem_shift >= {1'b0, op2_q});
  assign rem_sub   = rem_shift[31:0] - op2_q;

  always_comb begin
    mul_neg = 1'b0;
    case (op_q)
      OP_MUL, OP_MULH: mul_neg = neg1_q ^ neg2_q;
      OP_MULHSU:       mul_neg = neg1_q;
      default:         mul_neg = 1'b0;
    endcase
  end

  assign prod_fix = mul_neg ? (64'd0 - prod_q) : prod_q;
  assign quo_fix  = ((op_q == OP_DIV) && (neg1_q ^ neg2_q) && (op2_q != 32'd0)) ?
                    (32'd0 - quo_q) : quo_q;
  assign rem_fix  = ((op_q == OP_REM) && neg1_q) ? (32'd0 - rem_q) : rem_q;

  always_comb begin
    fix_result = 32'd0;
    case (op_q)
      OP_MUL:                       fix_result = prod_fix[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[63:32];
      OP_DIV, OP_DIVU:              fix_result = quo_fix;
      OP_REM, OP_REMU:              fix_result = rem_fix;
      default:                      fix_result = 32'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    prod_d   = prod_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = bus.opcode;
          op1_d  = bus.operator_1_c;
          op2_d  = bus.operator_2_c;
          neg1_d = bus.neg_1;
          neg2_d = bus.neg_2;
          cnt_d  = 6'd0;
          if ((in_is_mul || in_is_div) && !early_out) begin
            state_d = S_CALC;
            prod_d  = {32'd0, bus.operator_2_c};
            quo_d   = bus.operator_1_c;
            rem_d   = 32'd0;
          end else begin
            // Preload the divide-by-zero outcome so FIX needs no special case.
            state_d = S_FIX;
            prod_d  = 64'd0;
            quo_d   = 32'hFFFF_FFFF;
            rem_d   = bus.operator_1_c;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 6'd1;
        if (q_is_mul) begin
          prod_d = {mul_sum, prod_q[31:1]};
        end else if (rem_ge) begin
          rem_d = rem_sub;
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_shift[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        if (cnt_q == 6'd31) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_result;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including the result capture in FIX.
    if (bus.flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      op_q     <= 5'd0;
      op1_q    <= 32'd0;
      op2_q    <= 32'd0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      prod_q   <= 64'd0;
      quo_q    <= 32'd0;
      rem_q    <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      prod_q   <= prod_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE) && !bus.flush;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed vector table, multi-cycle corner
// sequences (flush, reset, hold) and randomized operations against a reference model.
module tb_muldiv_iter;

  localparam logic [4:0] OP_MUL    = 5'b00010;
  localparam logic [4:0] OP_MULH   = 5'b00011;
  localparam logic [4:0] OP_MULHSU = 5'b00100;
  localparam logic [4:0] OP_MULHU  = 5'b00101;
  localparam logic [4:0] OP_DIV    = 5'b00110;
  localparam logic [4:0] OP_DIVU   = 5'b00111;
  localparam logic [4:0] OP_REM    = 5'b01000;
  localparam logic [4:0] OP_REMU   = 5'b01001;
  localparam logic [4:0] OP_BAD    = 5'b11111;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] m1;
    logic [31:0] m2;
    logic        n1;
    logic        n2;
    logic [31:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  muldiv_iter_if bus ();

  muldiv_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  vec_t        vq[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_result = 32'd0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: plain RISC-V M-extension arithmetic on the original operands.
  function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, sub;
    logic [63:0] ua, ub, p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    sub = longint'(ub);
    p   = 64'd0;
    case (op)
      OP_MUL:    begin p = sa * sb;  return p[31:0];  end
      OP_MULH:   begin p = sa * sb;  return p[63:32]; end
      OP_MULHSU: begin p = sa * sub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub;  return p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_known(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic int exp_latency(input logic [4:0] op, input logic [31:0] m2);
    if (!is_known(op)) return 2;
    if (EARLY && m2 == 32'd0) return 2;
    return 34;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [4:0] op, input logic [31:0] m1, input logic [31:0] m2,
                       input logic n1, input logic n2);
    @(negedge clk);
    check("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid     = 1'b1;
    bus.opcode       = op;
    bus.operator_1_c = m1;
    bus.operator_2_c = m2;
    bus.neg_1        = n1;
    bus.neg_2        = n2;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
  endtask

  // Waits for out_valid (latency counted from the accept edge), checks the result,
  // holds out_ready low for 'hold' cycles, then completes the handshake.
  task automatic collect(input string name, input int exp_lat, input int hold);
    int          lat;
    logic [31:0] exp;
    lat = 1;
    while (!bus.out_valid && lat < 80) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else begin
      exp = 32'hDEAD_BEEF;
      check({name, "_scoreboard_empty"}, 32'd1, 32'd0);
    end
    check({name, "_result"}, bus.result, exp);
    last_result = exp;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({name, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check({name, "_hold_result"}, bus.result, exp);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({name, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
    check({name, "_ready_after_done"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check(name, seen, 32'd0);
  endtask

  task automatic add_vec(input string name, input logic [4:0] op, input logic [31:0] m1,
                         input logic [31:0] m2, input logic n1, input logic n2,
                         input logic [31:0] exp);
    vec_t v;
    v.name = name; v.op = op; v.m1 = m1; v.m2 = m2; v.n1 = n1; v.n2 = n2; v.exp = exp;
    vq.push_back(v);
  endtask

  // Upstream sign conversion: signed operands become magnitude + sign bit.
  task automatic to_mag(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] m1, output logic [31:0] m2,
                        output logic n1, output logic n2);
    bit s1, s2;
    s1 = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    s2 = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    n1 = a[31];
    n2 = b[31];
    m1 = (s1 && a[31]) ? (32'd0 - a) : a;
    m2 = (s2 && b[31]) ? (32'd0 - b) : b;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 100);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [4:0]  ops[8];
    logic [4:0]  op;
    logic [31:0] a, b, m1, m2;
    logic        n1, n2;

    ops = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.opcode       = 5'd0;
    bus.operator_1_c = 32'd0;
    bus.operator_2_c = 32'd0;
    bus.neg_1        = 1'b0;
    bus.neg_2        = 1'b0;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", {31'd0, bus.in_ready}, 32'd1);
    bus.flush = 1'b1;
    #1;
    check("ready_low_with_flush", {31'd0, bus.in_ready}, 32'd0);
    bus.flush = 1'b0;

    // Directed vectors (magnitude form, as delivered by the upstream converter).
    add_vec("mul_7x-3",      OP_MUL,    32'd7,          32'd3,          1'b0, 1'b1, 32'hFFFF_FFEB);
    add_vec("mulh_min_sq",   OP_MULH,   32'h8000_0000,  32'h8000_0000,  1'b1, 1'b1, 32'h4000_0000);
    add_vec("div_-7/2",      OP_DIV,    32'd7,          32'd2,          1'b1, 1'b0, 32'hFFFF_FFFD);
    add_vec("rem_-7/2",      OP_REM,    32'd7,          32'd2,          1'b1, 1'b0, 32'hFFFF_FFFF);
    add_vec("div_5/0",       OP_DIV,    32'd5,          32'd0,          1'b0, 1'b0, 32'hFFFF_FFFF);
    add_vec("rem_5/0",       OP_REM,    32'd5,          32'd0,          1'b0, 1'b0, 32'h0000_0005);
    add_vec("div_-5/0",      OP_DIV,    32'd5,          32'd0,          1'b1, 1'b0, 32'hFFFF_FFFF);
    add_vec("rem_-5/0",      OP_REM,    32'd5,          32'd0,          1'b1, 1'b0, 32'hFFFF_FFFB);
    add_vec("div_overflow",  OP_DIV,    32'h8000_0000,  32'd1,          1'b1, 1'b1, 32'h8000_0000);
    add_vec("rem_overflow",  OP_REM,    32'h8000_0000,  32'd1,          1'b1, 1'b1, 32'h0000_0000);
    add_vec("mulhu_max",     OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1'b1, 32'hFFFF_FFFE);
    add_vec("mulhsu_-1xmax", OP_MULHSU, 32'd1,          32'hFFFF_FFFF,  1'b1, 1'b1, 32'hFFFF_FFFF);
    add_vec("divu_100/7",    OP_DIVU,   32'd100,        32'd7,          1'b0, 1'b0, 32'd14);
    add_vec("remu_100/7",    OP_REMU,   32'd100,        32'd7,          1'b0, 1'b0, 32'd2);
    add_vec("div_6/-3",      OP_DIV,    32'd6,          32'd3,          1'b0, 1'b1, 32'hFFFF_FFFE);
    add_vec("bad_opcode",    OP_BAD,    32'd9,          32'd9,          1'b0, 1'b0, 32'd0);

    for (int i = 0; i < vq.size(); i++) begin
      exp_q.push_back(vq[i].exp);
      issue(vq[i].op, vq[i].m1, vq[i].m2, vq[i].n1, vq[i].n2);
      collect(vq[i].name, exp_latency(vq[i].op, vq[i].m2), (i == 0) ? 5 : int'($urandom_range(0, 2)));
    end

    // Flush at CALC cycle 10: back to idle, no result, previous result untouched.
    issue(OP_MUL, 32'd1234, 32'd5678, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_busy", {31'd0, bus.busy}, 32'd0);
    check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("flush_result_kept", bus.result, last_result);
    check("flush_ready_low", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("ready_after_flush", {31'd0, bus.in_ready}, 32'd1);
    watch_no_valid("flush_no_valid", 40);
    exp_q.push_back(32'd1234 * 32'd5678);
    issue(OP_MUL, 32'd1234, 32'd5678, 1'b0, 1'b0);
    collect("after_flush", 34, 1);

    // Flush together with a request: request must be dropped.
    @(negedge clk);
    bus.flush        = 1'b1;
    bus.in_valid     = 1'b1;
    bus.opcode       = OP_DIVU;
    bus.operator_1_c = 32'd50;
    bus.operator_2_c = 32'd5;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush_beats_valid", {31'd0, bus.busy}, 32'd0);
    watch_no_valid("flush_valid_no_result", 40);

    // Reset in the middle of CALC: immediate reset values, nothing produced.
    issue(OP_DIV, 32'd1000, 32'd7, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready", {31'd0, bus.in_ready}, 32'd1);
    watch_no_valid("midrst_no_valid", 40);

    // Randomized operations against the reference model.
    for (int r = 0; r < 40; r++) begin
      op = ($urandom_range(0, 9) == 0) ? 5'b00000 : ops[$urandom_range(0, 7)];
      a  = rand_operand();
      b  = rand_operand();
      to_mag(op, a, b, m1, m2, n1, n2);
      exp_q.push_back(ref_model(op, a, b));
      issue(op, m1, m2, n1, n2);
      collect($sformatf("rand%0d_op%0h_%h_%h", r, op, a, b), exp_latency(op, m2),
              int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound in case a handshake never completes.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_iter.md
MULDIV_ITER -- requirements
Module: muldiv_iter

Interface
REQ-001 SHALL expose the following ports, clock and reset first: clk input 1 is the single clock; rst_n input 1 is the asynchronous active-low reset.
REQ-002 in_valid input 1: operation request. in_ready output 1: unit can accept.
REQ-003 opcode input 5: 00010 MUL, 00011 MULH, 00100 MULHSU, 00101 MULHU, 00110 DIV, 00111 DIVU, 01000 REM, 01001 REMU.
REQ-004 operator_1_c input 32 and operator_2_c input 32: operand magnitudes after upstream sign conversion, unsigned for U-variants.
REQ-005 neg_1 input 1 and neg_2 input 1: original sign bits (bit 31) of the unconverted operands.
REQ-006 flush input 1: synchronous abort of the current operation.
REQ-007 out_valid output 1, out_ready input 1, result output 32, busy output 1.

Function
REQ-008 Accept on the rising edge where in_valid && in_ready; latch opcode, both operands, neg_1 and neg_2.
REQ-009 in_ready SHALL equal (state==IDLE) && !flush; busy SHALL equal (state!=IDLE).
REQ-010 FSM states IDLE, CALC, FIX, DONE; transitions IDLE->CALC on accept; CALC->FIX after 32 iterations; FIX->DONE; DONE->IDLE on out_valid && out_ready.
REQ-011 A 6-bit iteration counter SHALL clear on accept and increment once per CALC cycle; CALC exits when the count reaches 31.
REQ-012 Multiply SHALL be radix-2 shift-add into a 64-bit unsigned product; MUL returns bits 31:0, all MULH-type opcodes return bits 63:32.
REQ-013 Divide SHALL be radix-2 restoring, producing a 32-bit quotient and a 32-bit remainder.
REQ-014 FIX SHALL negate the 64-bit product when (neg_1^neg_2) for MUL/MULH, and when neg_1 for MULHSU; it SHALL never negate for MULHU.
REQ-015 FIX SHALL negate the quotient for DIV when (neg_1^neg_2) and the divisor is nonzero, and negate the remainder for REM when neg_1.
REQ-016 Divide by zero: DIV/DIVU quotient 0xFFFFFFFF; REM/REMU remainder = dividend (re-signed with neg_1 for REM).
REQ-017 Overflow case, DIV magnitudes 0x80000000/1 with neg_1=neg_2=1: result 0x80000000; the matching REM result is 0.
REQ-018 Unrecognised opcode: accepted, skips CALC (IDLE->FIX), result 0.
REQ-019 out_valid SHALL be high only in DONE; result SHALL be registered and held stable while out_valid && !out_ready.
REQ-020 Latency: out_valid rises 34 cycles after the accept edge (32 CALC, 1 FIX, 1 DONE entry).
REQ-021 flush in any state SHALL force IDLE at the next edge; out_valid is then low and result unchanged.
REQ-022 flush asserted together with in_valid SHALL take priority; the request is not accepted.
REQ-023 Back-to-back: the cycle after DONE->IDLE, in_ready SHALL be high; no accept occurs in the same edge as the DONE handshake.

Reset
REQ-024 On rst_n low, asynchronously: state IDLE, counter 0, out_valid 0, busy 0, result 0, and all internal product/quotient/remainder registers 0.
REQ-025 in_ready SHALL read 1 from the first cycle after reset release, or 0 while flush is high.
REQ-026 Reset asserted mid-operation SHALL discard the operation with no result produced.

Configuration
REQ-027 Macro MULDIV_EARLY_OUT_EN defined: an accept with operator_2_c==0 SHALL skip CALC (IDLE->FIX), so out_valid rises 2 cycles after accept with the REQ-016 values or product 0.
REQ-028 Macro MULDIV_EARLY_OUT_EN undefined: every recognised opcode uses the full 34-cycle latency.

Verification
REQ-029 MUL, op1_c=7, op2_c=3, neg_2=1 -> result 0xFFFFFFEB at accept+34, out_valid held until out_ready.
REQ-030 MULH, both operands 0x80000000, neg_1=neg_2=1 -> result 0x40000000.
REQ-031 DIV 7/2 with neg_1=1 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-032 DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 0x00000005; with MULDIV_EARLY_OUT_EN both at accept+2.
REQ-033 flush at CALC cycle 10 -> IDLE next edge, no out_valid; next request completes correctly.
REQ-034 rst_n low during CALC -> all outputs at reset values immediately; in_ready high after release.
